nvm_read_ctrl: RTL and testbench

- Read-path counterpart of the NVM flush controller.
- Accepts word-burst read requests on virtual addresses from the AHB-side slave.
- Translates each logical page to a physical {block, page} through the mapping-table lookup port, then issues per-word flash reads and returns the data with a valid/ack handshake.
- Defers new requests while garbage collection is moving pages. Flags unmapped pages and flash timeouts as errors.

---
 rtl/nvm_pkg.sv | 36 +++
 rtl/nvm_rd_timeout.sv | 29 ++
 rtl/nvm_read_ctrl.sv | 151 +++++++++++++++
 tb/tb_nvm_read_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvm_pkg.sv
// Shared NVM types and constants used by the flush and read-path controllers.
// Flash byte addresses are {block, page, word offset, 2'b00}.
package nvm_pkg;

    localparam int WORD_W         = 32;
    localparam int VIRTUAL_ADDR_W = 16;
    localparam int FLASH_ADDR_W   = 28;
    localparam int BLOCK_W        = 10;
    localparam int PAGE_W         = 6;
    localparam int OFFSET_W       = VIRTUAL_ADDR_W - PAGE_W;
    localparam int LEN_W          = 4;
    localparam int TIMEOUT_CYC    = 255;
    localparam int TMO_W          = 8;

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [BLOCK_W-1:0]      block_t;
    typedef logic [PAGE_W-1:0]       page_t;
    typedef logic [PAGE_W-1:0]       lpn_t;
    typedef logic [OFFSET_W-1:0]     offset_t;
    typedef logic [LEN_W-1:0]        len_t;
    typedef logic [FLASH_ADDR_W-1:0] flash_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        WAIT,
        RETURN,
        ERROR
    } rd_state_t;

    function automatic flash_addr_t make_flash_addr(block_t blk, page_t pg, offset_t off);
        return {blk, pg, off, 2'b00};
    endfunction

endpackage

// File: rtl/nvm_rd_timeout.sv
// Saturating wait-cycle counter for flash reads. expired marks the last
// enabled cycle before LIMIT cycles have elapsed since the last clear.
module nvm_rd_timeout
    import nvm_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = en && (count_q == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/nvm_read_ctrl.sv
// NVM read path: translates a logical page through the mapping table, then
// issues one flash read per burst word and returns beats with a valid/ack handshake.
module nvm_read_ctrl
    import nvm_pkg::*;
(
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      rd_req,
    input  logic [VIRTUAL_ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]          rd_len,
    output logic                      rd_ready,
    output logic [WORD_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      rd_last,
    output logic                      rd_err,
    input  logic                      rd_ack,
    input  logic                      gc_busy,
    output logic                      map_req,
    output logic [PAGE_W-1:0]         map_lpn,
    input  logic                      map_ack,
    input  logic                      map_hit,
    input  logic [BLOCK_W-1:0]        map_block,
    input  logic [PAGE_W-1:0]         map_page,
    output logic                      flash_ren,
    output logic [FLASH_ADDR_W-1:0]   flash_addr,
    input  logic [WORD_W-1:0]         flash_rdata,
    input  logic                      flash_rvalid,
    output logic [2:0]                dbg_state
);

    // Handshakes: a request is taken on a rising CLK edge where rd_req && rd_ready;
    // a beat is consumed on an edge where rd_valid && rd_ack, and rd_data/rd_last/
    // rd_err stay constant until then; map_req/map_lpn hold until map_ack.

    rd_state_t state;
    offset_t   off_q;
    len_t      len_q;
    len_t      beat_cnt;
    block_t    blk_q;
    page_t     pg_q;
    logic      tmo_expired;

    assign rd_ready  = (state == IDLE) && !gc_busy;
    assign dbg_state = state;

    nvm_rd_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (state == ISSUE),
        .en      (state == WAIT),
        .expired (tmo_expired)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            off_q      <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            blk_q      <= '0;
            pg_q       <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_err     <= 1'b0;
            map_req    <= 1'b0;
            map_lpn    <= '0;
            flash_ren  <= 1'b0;
            flash_addr <= '0;
        end else begin
            flash_ren <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_req && rd_ready) begin
                        map_lpn  <= rd_addr[VIRTUAL_ADDR_W-1 -: PAGE_W];
                        off_q    <= rd_addr[OFFSET_W-1:0];
                        len_q    <= rd_len;
                        beat_cnt <= '0;
                        map_req  <= 1'b1;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (map_ack) begin
                        map_req <= 1'b0;
                        if (map_hit) begin
                            blk_q      <= map_block;
                            pg_q       <= map_page;
                            flash_ren  <= 1'b1;
                            flash_addr <= make_flash_addr(map_block, map_page, off_q);
                            state      <= ISSUE;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_err   <= 1'b1;
                            rd_last  <= 1'b1;
                            rd_data  <= '0;
                            state    <= ERROR;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Data arriving in the final timeout cycle still wins.
                    if (flash_rvalid) begin
                        rd_data  <= flash_rdata;
                        rd_valid <= 1'b1;
                        rd_last  <= (beat_cnt == len_q);
                        state    <= RETURN;
                    end else if (tmo_expired) begin
                        rd_valid <= 1'b1;
                        rd_err   <= 1'b1;
                        rd_last  <= 1'b1;
                        rd_data  <= '0;
                        state    <= ERROR;
                    end
                end
                RETURN: begin
                    if (rd_ack) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        rd_data  <= '0;
                        if (rd_last) begin
                            state <= IDLE;
                        end else begin
                            // Offset wraps inside the page; the mapping is reused.
                            beat_cnt   <= beat_cnt + 1'b1;
                            off_q      <= off_q + 1'b1;
                            flash_ren  <= 1'b1;
                            flash_addr <= make_flash_addr(blk_q, pg_q, off_q + 1'b1);
                            state      <= ISSUE;
                        end
                    end
                end
                ERROR: begin
                    if (rd_ack) begin
                        rd_valid <= 1'b0;
                        rd_err   <= 1'b0;
                        rd_last  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvm_read_ctrl.sv
// Directed and randomized bench for nvm_read_ctrl with mapping-table and
// flash responders and a burst-level reference model.
module tb_nvm_read_ctrl;
    import nvm_pkg::*;

    localparam int BEAT_W = 34;  // {err, last, data}

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic nRST;
    int   cyc_n = 0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_n <= cyc_n + 1;

    // ---------------- DUT ----------------
    logic              rd_req, rd_ready, rd_valid, rd_last, rd_err, rd_ack, gc_busy;
    logic [15:0]       rd_addr;
    logic [3:0]        rd_len;
    word_t             rd_data;
    logic              map_req, map_ack, map_hit;
    lpn_t              map_lpn;
    block_t            map_block;
    page_t             map_page;
    logic              flash_ren, flash_rvalid;
    flash_addr_t       flash_addr;
    word_t             flash_rdata;
    logic [2:0]        dbg_state;

    nvm_read_ctrl dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .rd_err       (rd_err),
        .rd_ack       (rd_ack),
        .gc_busy      (gc_busy),
        .map_req      (map_req),
        .map_lpn      (map_lpn),
        .map_ack      (map_ack),
        .map_hit      (map_hit),
        .map_block    (map_block),
        .map_page     (map_page),
        .flash_ren    (flash_ren),
        .flash_addr   (flash_addr),
        .flash_rdata  (flash_rdata),
        .flash_rvalid (flash_rvalid),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- environment: mapping table ----------------
    block_t blk_tab[64];
    page_t  pg_tab[64];
    int     map_lat_cfg = 0;
    logic   map_hit_cfg = 1'b1;
    int     map_req_rises = 0;

    initial begin
        int   wait_n;
        logic req_prev;
        wait_n = 0; req_prev = 1'b0;
        map_ack = 1'b0; map_hit = 1'b0; map_block = '0; map_page = '0;
        forever begin
            @(negedge CLK);
            if (map_req && !req_prev) map_req_rises++;
            req_prev = map_req;
            if (map_ack) begin
                map_ack = 1'b0; map_hit = 1'b0; map_block = '0; map_page = '0; wait_n = 0;
            end else if (map_req) begin
                if (wait_n >= map_lat_cfg) begin
                    map_ack   = 1'b1;
                    map_hit   = map_hit_cfg;
                    map_block = blk_tab[map_lpn];
                    map_page  = pg_tab[map_lpn];
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // ---------------- environment: flash ----------------
    int          fl_lat_cfg = 1;
    logic        fl_abort = 1'b0;
    logic        fl_ovr_en = 1'b0;
    word_t       fl_ovr = '0;
    int          fl_ren_cnt = 0;
    int          fl_ren_cyc = 0;
    flash_addr_t fl_addr_q[$];

    function automatic word_t fdata(input flash_addr_t a);
        return (word_t'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    initial begin
        int          cnt;
        flash_addr_t pend;
        cnt = 0; pend = '0;
        flash_rvalid = 1'b0; flash_rdata = '0;
        forever begin
            @(negedge CLK);
            flash_rvalid = 1'b0;
            flash_rdata  = $urandom;
            if (fl_abort) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    flash_rvalid = 1'b1;
                    flash_rdata  = fl_ovr_en ? fl_ovr : fdata(pend);
                end
            end
            if (flash_ren) begin
                fl_ren_cnt++;
                fl_ren_cyc = cyc_n;
                fl_addr_q.push_back(flash_addr);
                pend = flash_addr;
                cnt  = fl_lat_cfg;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic flash_addr_t model_addr(input logic [15:0] va, input int i);
        int lpn, off;
        lpn = int'(va) / 1024;
        off = (int'(va) % 1024 + i) % 1024;
        return flash_addr_t'(int'(blk_tab[lpn]) * (1 << 18) + int'(pg_tab[lpn]) * (1 << 12) + off * 4);
    endfunction

    function automatic word_t model_data(input flash_addr_t a);
        return fl_ovr_en ? fl_ovr : fdata(a);
    endfunction

    // ---------------- driver tasks ----------------
    int last_base = 0;
    int last_first_cyc = 0;

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!rd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_ready"}, rd_ready, 1);
    endtask

    task automatic run_burst(input logic [15:0] va, input logic [3:0] len, input logic hit,
                             input int mlat, input int flat, input int hold, input logic gc_mid,
                             input string tag);
        logic [BEAT_W-1:0] exp_q[$];
        flash_addr_t       exp_a[$];
        logic [BEAT_W-1:0] e;
        int                base, rises0, first_cyc, ren_seen, hold_n;
        logic              done, seen;
        word_t             held;

        map_lat_cfg = mlat; map_hit_cfg = hit; fl_lat_cfg = flat;
        if (!hit) begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
        end else if (flat > TIMEOUT_CYC) begin
            exp_a.push_back(model_addr(va, 0));
            exp_q.push_back({1'b1, 1'b1, 32'h0});
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_a.push_back(model_addr(va, i));
                exp_q.push_back({1'b0, (i == int'(len)), model_data(model_addr(va, i))});
            end
        end

        wait_ready(tag);
        base = fl_addr_q.size(); rises0 = map_req_rises;
        rd_req = 1'b1; rd_addr = va; rd_len = len;
        @(negedge CLK);
        rd_req = 1'b0; rd_addr = 16'($urandom); rd_len = 4'($urandom);
        if (gc_mid) gc_busy = 1'b1;

        done = 1'b0; seen = 1'b0; hold_n = 0; first_cyc = -1; ren_seen = 0; held = '0;
        for (int c = 0; c < 700 && !done; c++) begin
            rd_ack = 1'b0;
            if (rd_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (first_cyc < 0) first_cyc = cyc_n;
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_beat"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_data"}, rd_data, e[31:0]);
                        check({tag, "_last"}, rd_last, e[32]);
                        check({tag, "_err"}, rd_err, e[33]);
                    end
                    hold_n = hold; held = rd_data; ren_seen = fl_ren_cnt;
                end else begin
                    check({tag, "_hold_data"}, rd_data, held);
                end
                if (hold_n == 0) begin
                    if (hold > 0) check({tag, "_hold_no_ren"}, fl_ren_cnt, ren_seen);
                    rd_ack = 1'b1; seen = 1'b0;
                    if (rd_last) done = 1'b1;
                end else begin
                    hold_n--;
                end
            end
            @(negedge CLK);
        end
        rd_ack = 1'b0;

        check({tag, "_done"}, done, 1);
        check({tag, "_beats_left"}, exp_q.size(), 0);
        check({tag, "_map_req_once"}, map_req_rises - rises0, 1);
        check({tag, "_ren_count"}, fl_addr_q.size() - base, exp_a.size());
        for (int i = 0; i < exp_a.size(); i++)
            if (base + i < fl_addr_q.size()) check({tag, "_flash_addr"}, fl_addr_q[base + i], exp_a[i]);
        last_base = base; last_first_cyc = first_cyc;
        gc_busy = 1'b0;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [9:0]  wrap_off[4];
        flash_addr_t a;
        int          rises0, nq;

        nRST = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_ack = 1'b0; gc_busy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            blk_tab[i] = block_t'($urandom);
            pg_tab[i]  = page_t'($urandom);
        end

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_state", dbg_state, IDLE);
        check("rst_ready", rd_ready, 1);
        check("rst_outputs", {rd_valid, rd_last, rd_err, map_req, flash_ren, rd_data}, 0);
        gc_busy = 1'b1;
        #1 check("rst_ready_gc", rd_ready, 0);
        @(negedge CLK);
        gc_busy = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);

        // single read
        blk_tab[1] = 10'h3; pg_tab[1] = 6'h2;
        fl_ovr_en = 1'b1; fl_ovr = 32'hDEADBEEF;
        run_burst(16'h0405, 4'd0, 1'b1, 0, 2, 0, 1'b0, "single");
        fl_ovr_en = 1'b0;
        a = fl_addr_q[last_base];
        check("single_addr_lit", a, {10'h3, 6'h2, 10'h005, 2'b00});
        check("single_latency", last_first_cyc - fl_ren_cyc, 3);
        check("single_ready_after", rd_ready, 1);

        // burst wrapping within the page
        wrap_off = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        run_burst({6'd7, 10'h3FE}, 4'd3, 1'b1, 2, 1, 1, 1'b0, "wrap");
        for (int i = 0; i < 4; i++) begin
            a = fl_addr_q[last_base + i];
            check("wrap_offset", a[11:2], wrap_off[i]);
        end

        // full-length burst
        run_burst({6'd9, 10'h3F8}, 4'd15, 1'b1, 1, 2, 0, 1'b0, "len16");

        // unmapped page
        run_burst({6'd20, 10'h010}, 4'd5, 1'b0, 1, 2, 0, 1'b0, "unmapped");

        // timeout; late rvalid lands while the error beat is held
        run_burst({6'd3, 10'h100}, 4'd2, 1'b1, 0, 300, 60, 1'b0, "timeout");
        check("timeout_cycles", last_first_cyc - fl_ren_cyc, TIMEOUT_CYC + 1);
        nq = fl_addr_q.size();
        repeat (3) @(negedge CLK);
        check("timeout_idle", dbg_state, IDLE);
        check("timeout_no_beat", rd_valid, 0);
        check("timeout_no_ren", fl_addr_q.size(), nq);

        // data arriving in the last allowed wait cycle
        run_burst({6'd4, 10'h020}, 4'd0, 1'b1, 0, TIMEOUT_CYC, 0, 1'b0, "rvalid_edge");

        // backpressure
        run_burst({6'd5, 10'h040}, 4'd2, 1'b1, 1, 3, 5, 1'b0, "backpressure");

        // gc_busy in IDLE blocks acceptance
        gc_busy = 1'b1;
        @(negedge CLK);
        check("gc_ready", rd_ready, 0);
        rises0 = map_req_rises;
        rd_req = 1'b1; rd_addr = 16'h1234; rd_len = 4'd1;
        repeat (3) @(negedge CLK);
        rd_req = 1'b0;
        @(negedge CLK);
        check("gc_no_lookup", map_req_rises - rises0, 0);
        check("gc_state", dbg_state, IDLE);
        gc_busy = 1'b0;
        @(negedge CLK);
        check("gc_ready_after", rd_ready, 1);

        // gc_busy raised mid-burst
        run_burst({6'd6, 10'h3FF}, 4'd3, 1'b1, 1, 2, 1, 1'b1, "gc_mid");

        // reset during WAIT
        map_lat_cfg = 0; map_hit_cfg = 1'b1; fl_lat_cfg = 300;
        rd_req = 1'b1; rd_addr = {6'd8, 10'h002}; rd_len = 4'd4;
        @(negedge CLK);
        rd_req = 1'b0;
        repeat (5) @(negedge CLK);
        check("rstmid_in_wait", dbg_state, WAIT);
        nRST = 1'b0; fl_abort = 1'b1;
        @(negedge CLK);
        check("rstmid_state", dbg_state, IDLE);
        check("rstmid_outputs", {rd_valid, rd_last, rd_err, map_req, flash_ren, map_lpn, flash_addr, rd_data}, 0);
        check("rstmid_ready", rd_ready, 1);
        nRST = 1'b1; fl_abort = 1'b0;
        @(negedge CLK);
        run_burst({6'd8, 10'h002}, 4'd1, 1'b1, 1, 2, 0, 1'b0, "after_rst");

        // randomized bursts
        for (int n = 0; n < 25; n++) begin
            run_burst(16'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
                      $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
